// File: rtl/init_reset_sequencer.sv
// -----------------------------------------------------------------------------
// init_reset_sequencer
//
// Turns the PolarFire init-monitor status into an ordered set of fabric reset
// releases. The four readiness inputs and the external push-button are
// synchronised. Combined readiness must hold for LOCK_FILTER cycles before
// sequencing starts. The NUM_STAGES reset domains are then released one by
// one, STAGE_DELAY cycles apart. If readiness drops or the button is pressed,
// all domains go back into reset together. INIT_TIMEOUT flags a device that
// never became ready.
//
// Ports
//   CLK                  in   system clock
//   RESET                in   asynchronous, active-high reset
//   FABRIC_POR_N         in   init monitor POR, active-low (async)
//   DEVICE_INIT_DONE     in   device init complete (async)
//   BANK_1_CALIB_STATUS  in   bank 1 I/O calibration complete (async)
//   PLL_LOCK             in   fabric PLL lock (async)
//   EXT_RST_N            in   external push-button reset, active-low (async)
//   STAGE_RESET_N        out  per-domain reset, active-low, bit 0 released first
//   INIT_SEQ_DONE        out  all stages released
//   INIT_TIMEOUT         out  sticky: readiness not reached in TIMEOUT_CYCLES
//   SEQ_STATE            out  current FSM state (debug)
// -----------------------------------------------------------------------------
module init_reset_sequencer #(
   parameter int NUM_STAGES     = 3,
   parameter int STAGE_DELAY    = 16,
   parameter int LOCK_FILTER    = 8,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FABRIC_POR_N,
   input  logic                  DEVICE_INIT_DONE,
   input  logic                  BANK_1_CALIB_STATUS,
   input  logic                  PLL_LOCK,
   input  logic                  EXT_RST_N,
   output logic [NUM_STAGES-1:0] STAGE_RESET_N,
   output logic                  INIT_SEQ_DONE,
   output logic                  INIT_TIMEOUT,
   output logic [2:0]            SEQ_STATE
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int FLT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
   localparam int DLY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
   localparam int IDX_W = $clog2(NUM_STAGES + 1);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      ST_WAIT_INIT = 3'd1,
      ST_FILTER    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_TIMEOUT   = 3'd5
   } state_t;

   // Synchroniser bit order: {por_n, dev_init, calib, lock, ext_rst_n}.
   // Reset to 0 so that HOLD is active while the chain refills after reset.
   logic [4:0] sync1_q, sync2_q;
   logic       ready, hold, go, abort;

   state_t                  state_q, state_d;
   logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [FLT_W-1:0]        filt_cnt_q, filt_cnt_d;
   logic [DLY_W-1:0]        dly_cnt_q, dly_cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0]   stage_q, stage_d;
   logic                    done_q, done_d;
   logic                    timeout_q, timeout_d;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {FABRIC_POR_N, DEVICE_INIT_DONE, BANK_1_CALIB_STATUS, PLL_LOCK, EXT_RST_N};
         sync2_q <= sync1_q;
      end
   end

   assign ready = &sync2_q[4:1];
   assign hold  = ~sync2_q[0];
   assign go    = ready & ~hold;
   // Loss of readiness while sequencing or running puts every domain back in reset.
   assign abort = ~go & ((state_q == ST_FILTER) | (state_q == ST_RELEASE) | (state_q == ST_RUN));

   always_comb begin
      state_d    = state_q;
      tmo_cnt_d  = '0;          // timeout counter only runs in WAIT_INIT
      filt_cnt_d = filt_cnt_q;
      dly_cnt_d  = dly_cnt_q;
      idx_d      = idx_q;
      stage_d    = stage_q;
      done_d     = done_q;
      timeout_d  = timeout_q;

      case (state_q)
         ST_WAIT_INIT: begin
            if (hold) begin
               tmo_cnt_d = '0;
            end else if (ready) begin
               state_d    = ST_FILTER;
               filt_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = ST_TIMEOUT;
               timeout_d = 1'b1;
            end else if (tmo_cnt_q != '1) begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end else begin
               tmo_cnt_d = tmo_cnt_q;
            end
         end
         ST_FILTER: begin
            if (filt_cnt_q == FLT_LAST) begin
               state_d   = ST_RELEASE;
               idx_d     = '0;
               dly_cnt_d = '0;
            end else begin
               filt_cnt_d = filt_cnt_q + FLT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (dly_cnt_q == DLY_LAST) begin
               for (int k = 0; k < NUM_STAGES; k++) begin
                  if (idx_q == IDX_W'(k)) stage_d[k] = 1'b1;
               end
               dly_cnt_d = '0;
               idx_d     = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end
            end else begin
               dly_cnt_d = dly_cnt_q + DLY_W'(1);
            end
         end
         ST_RUN: begin
         end
         ST_TIMEOUT: begin
            if (go) begin
               state_d    = ST_FILTER;
               filt_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_WAIT_INIT;
         end
      endcase

      // Overrides any terminal count reached on the same edge.
      if (abort) begin
         state_d    = ST_WAIT_INIT;
         tmo_cnt_d  = '0;
         filt_cnt_d = '0;
         dly_cnt_d  = '0;
         idx_d      = '0;
         stage_d    = '0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_WAIT_INIT;
         tmo_cnt_q  <= '0;
         filt_cnt_q <= '0;
         dly_cnt_q  <= '0;
         idx_q      <= '0;
         stage_q    <= '0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_cnt_q  <= tmo_cnt_d;
         filt_cnt_q <= filt_cnt_d;
         dly_cnt_q  <= dly_cnt_d;
         idx_q      <= idx_d;
         stage_q    <= stage_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   assign STAGE_RESET_N = stage_q;
   assign INIT_SEQ_DONE = done_q;
   assign INIT_TIMEOUT  = timeout_q;
   assign SEQ_STATE     = state_q;

endmodule
